// File: rtl/sample_decompress_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_decompress_pkg
//  Description : Shared sampler constants and slot/channel bit-range helpers,
//                common to the change-compression encoder and its decoder.
//                Exposes the default channel count, the default sample
//                width, and slot_lsb(), which maps a slot or channel index
//                to the LSB of its slice in a packed word.
//  Revision    : 1.0 - initial release
// ============================================================================
package sample_decompress_pkg;

  localparam int SAMPLER_CHANNEL   = 8;
  localparam int SAMPLER_DATA_BITS = 16;

  // Slot k (or channel k of a frame) occupies [slot_lsb+data_bits-1 : slot_lsb].
  function automatic int slot_lsb(input int k, input int data_bits);
    return k * data_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_decompress_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_decompress_if
//  Description : Frame stream bundle between the capture-buffer readout and
//                the decompressor, plus the decompressor's reconstructed
//                frame output.
//                  in_valid / data_compressed_in / diff_bitset_in : input beat
//                  out_valid / data_out / diff_out                : output beat
//                  missing_keyframe                               : sticky flag
//                Modports: master (stream source / sink), slave (decompressor).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sample_decompress_if #(
  parameter int CHANNEL   = 8,
  parameter int DATA_BITS = 16
);

  logic                          in_valid;
  logic [DATA_BITS*CHANNEL-1:0]  data_compressed_in;
  logic [CHANNEL-1:0]            diff_bitset_in;
  logic                          out_valid;
  logic [DATA_BITS*CHANNEL-1:0]  data_out;
  logic [CHANNEL-1:0]            diff_out;
  logic                          missing_keyframe;

  modport master (
    output in_valid, data_compressed_in, diff_bitset_in,
    input  out_valid, data_out, diff_out, missing_keyframe
  );

  modport slave (
    input  in_valid, data_compressed_in, diff_bitset_in,
    output out_valid, data_out, diff_out, missing_keyframe
  );

endinterface
`default_nettype wire

// File: rtl/sample_decompress_data_expansion.sv
`default_nettype none
// ============================================================================
//  Module      : data_expansion
//  Description : One decompressor pipeline stage, resolving channel OFFSET.
//                The encoder packs the highest-index changed channel first,
//                so when stages run from the top channel downwards the value
//                for this stage's channel (if it changed) is always slot 0
//                of the remaining word.
//  Ports       : clk, rst_n                     clock, async active-low reset
//                in_valid/in_diff/in_word/in_frame     upstream stage state
//                out_valid/out_diff/out_word/out_frame registered stage state
//                out_miss  this beat used channel OFFSET before it was loaded
//  Revision    : 1.0 - initial release
// ============================================================================
module data_expansion
  import sample_decompress_pkg::*;
#(
  parameter int OFFSET    = 0,
  parameter int DATA_BITS = 16,
  parameter int CHANNEL   = 8
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         in_valid,
  input  wire logic [CHANNEL-1:0]           in_diff,
  input  wire logic [DATA_BITS*CHANNEL-1:0] in_word,
  input  wire logic [DATA_BITS*CHANNEL-1:0] in_frame,
  output logic                              out_valid,
  output logic [CHANNEL-1:0]                out_diff,
  output logic [DATA_BITS*CHANNEL-1:0]      out_word,
  output logic [DATA_BITS*CHANNEL-1:0]      out_frame,
  output logic                              out_miss
);

  localparam int C_W       = DATA_BITS * CHANNEL;
  localparam int C_LSB     = slot_lsb(OFFSET, DATA_BITS);
  localparam int C_SLOT0   = slot_lsb(0, DATA_BITS);

  logic                 r_valid;
  logic [CHANNEL-1:0]   r_diff;
  logic [C_W-1:0]       r_word;
  logic [C_W-1:0]       r_frame;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_loaded;

  logic                 w_take;
  logic [DATA_BITS-1:0] w_slot0;
  logic [C_W-1:0]       w_frame;

  assign w_take  = in_diff[OFFSET];
  assign w_slot0 = in_word[C_SLOT0 +: DATA_BITS];

  // Combinational so the top can fold it into the sticky flag on the same
  // edge that this stage registers the offending frame.
  assign out_miss = in_valid & ~w_take & ~r_loaded;

  always_comb begin
    w_frame = in_frame;
    w_frame[C_LSB +: DATA_BITS] = w_take ? w_slot0 : r_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_diff   <= '0;
      r_word   <= '0;
      r_frame  <= '0;
      r_hold   <= '0;
      r_loaded <= 1'b0;
    end else begin
      r_valid <= in_valid;
      // Bubbles leave data, hold and loaded untouched.
      if (in_valid) begin
        r_diff  <= in_diff;
        r_frame <= w_frame;
        r_word  <= w_take ? (in_word >> DATA_BITS) : in_word;
        if (w_take) begin
          r_hold   <= w_slot0;
          r_loaded <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_diff  = r_diff;
  assign out_word  = r_word;
  assign out_frame = r_frame;

endmodule
`default_nettype wire

// File: rtl/sample_decompress.sv
`default_nettype none
// ============================================================================
//  Module      : sample_decompress
//  Description : Rebuilds full CHANNEL x DATA_BITS sample frames from the
//                change-compressed stream (packed changed values + diff
//                bitset). CHANNEL chained stages, one per channel from the
//                highest index down; latency CHANNEL cycles, one frame per
//                cycle, no backpressure.
//  Ports       : clk    clock
//                rst_n  asynchronous active-low reset
//                bus    sample_decompress_if.slave (input beat, output frame,
//                       diff_out, sticky missing_keyframe)
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_decompress
  import sample_decompress_pkg::*;
#(
  parameter int CHANNEL   = SAMPLER_CHANNEL,
  parameter int DATA_BITS = SAMPLER_DATA_BITS
) (
  input wire logic            clk,
  input wire logic            rst_n,
  sample_decompress_if.slave  bus
);

  localparam int C_W = DATA_BITS * CHANNEL;

  logic [CHANNEL:0]   w_valid;
  logic [CHANNEL-1:0] w_diff  [CHANNEL+1];
  logic [C_W-1:0]     w_word  [CHANNEL+1];
  logic [C_W-1:0]     w_frame [CHANNEL+1];
  logic [CHANNEL-1:0] w_miss;
  logic [C_W-1:0]     w_unused_word;
  logic               r_missing;

  assign w_valid[0] = bus.in_valid;
  assign w_diff[0]  = bus.diff_bitset_in;
  assign w_word[0]  = bus.data_compressed_in;
  assign w_frame[0] = '0;

  generate
    for (genvar s = 0; s < CHANNEL; s++) begin : g_stage
      data_expansion #(
        .OFFSET    (CHANNEL - 1 - s),
        .DATA_BITS (DATA_BITS),
        .CHANNEL   (CHANNEL)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_valid[s]),
        .in_diff   (w_diff[s]),
        .in_word   (w_word[s]),
        .in_frame  (w_frame[s]),
        .out_valid (w_valid[s+1]),
        .out_diff  (w_diff[s+1]),
        .out_word  (w_word[s+1]),
        .out_frame (w_frame[s+1]),
        .out_miss  (w_miss[s])
      );
    end
  endgenerate

  // Whatever packed data is left after the last stage is don't-care slots.
  assign w_unused_word = w_word[CHANNEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_missing <= 1'b0;
    end else if (|w_miss) begin
      r_missing <= 1'b1;
    end
  end

  assign bus.out_valid        = w_valid[CHANNEL];
  assign bus.data_out         = w_frame[CHANNEL];
  assign bus.diff_out         = w_diff[CHANNEL];
  assign bus.missing_keyframe = r_missing;

endmodule
`default_nettype wire
